// File: rtl/uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder
//
// Buffered, paced byte source for a simplex UART transmitter that has no
// busy/ready handshake. Producer bytes are queued in a circular FIFO; the
// pacing FSM pops one byte at a time, presents it on o_frame together with a
// single-cycle o_send pulse, and then waits a fixed frame-hold interval
// (10-bit frame + 1 guard bit) before the next pop.
//
// Ports:
//   CLK         system clock, all logic on the rising edge
//   RST         synchronous reset, active-high
//   i_wr_en     write strobe; byte stored when i_wr_en=1 and o_full=0
//   i_wr_data   byte to enqueue
//   o_full      FIFO holds Depth entries (registered)
//   o_empty     FIFO holds 0 entries (registered)
//   o_level     current entry count (registered)
//   o_overflow  sticky flag, set by a write attempt while full
//   o_send      one-cycle pulse to the transmitter's i_send
//   o_frame     byte for the transmitter's i_frame, stable through the hold
//   o_busy      high while a frame is being sent or held
// -----------------------------------------------------------------------------
module uart_tx_feeder #(
   parameter int ClockFrequency = 50_000_000,
   parameter int BaudRate       = 115200,
   parameter int Depth          = 16
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       i_wr_en,
   input  logic [7:0]                 i_wr_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(Depth+1)-1:0] o_level,
   output logic                       o_overflow,
   output logic                       o_send,
   output logic [7:0]                 o_frame,
   output logic                       o_busy
);

   // ---------------------------------------------------------------------------
   // Derived constants
   // ---------------------------------------------------------------------------
   localparam int TicksPerBit = ClockFrequency / BaudRate;
   localparam int HoldCycles  = 11 * TicksPerBit;
   localparam int PtrW        = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int LvlW        = $clog2(Depth + 1);
   localparam int CntW        = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;

   localparam logic [LvlW-1:0] LvlFull  = LvlW'(Depth);
   localparam logic [CntW-1:0] HoldLoad = CntW'(HoldCycles - 1);

   // Reject parameter sets that would give a zero bit period or a FIFO whose
   // pointers cannot wrap naturally.
   generate
      if (TicksPerBit < 1) begin : g_bad_baud
         $error("uart_tx_feeder: ClockFrequency/BaudRate must be at least 1");
      end
      if ((Depth < 2) || ((Depth & (Depth - 1)) != 0)) begin : g_bad_depth
         $error("uart_tx_feeder: Depth must be a power of two and at least 2");
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // State and storage
   // ---------------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t            state_r;
   logic [7:0]        mem_r [Depth];
   logic [PtrW-1:0]   wr_ptr_r;
   logic [PtrW-1:0]   rd_ptr_r;
   logic [LvlW-1:0]   level_r;
   logic [LvlW-1:0]   level_next_s;
   logic              full_r;
   logic              empty_r;
   logic              overflow_r;
   logic              wr_ok_s;
   logic              pop_s;
   logic [CntW-1:0]   hold_cnt_r;
   logic              send_r;
   logic              busy_r;
   logic [7:0]        frame_r;

   // Write acceptance, pop request and next FIFO level.
   always_comb begin
      wr_ok_s      = 1'b0;
      pop_s        = 1'b0;
      level_next_s = level_r;

      // A write while full is dropped even if a pop happens in the same cycle.
      wr_ok_s = i_wr_en & ~full_r;
      // Only the idle state drains the FIFO; the registered empty flag is the
      // view the FSM acts on.
      pop_s   = (state_r == ST_IDLE) & ~empty_r;

      case ({wr_ok_s, pop_s})
         2'b10:   level_next_s = level_r + LvlW'(1);
         2'b01:   level_next_s = level_r - LvlW'(1);
         default: level_next_s = level_r;
      endcase
   end

   // FIFO storage array; not reset, stale contents are never read because
   // the level counter gates every pop.
   always_ff @(posedge CLK) begin
      if (wr_ok_s) begin
         mem_r[wr_ptr_r] <= i_wr_data;
      end
   end

   // FIFO pointers, level and status flags.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         level_r    <= '0;
         full_r     <= 1'b0;
         empty_r    <= 1'b1;
         overflow_r <= 1'b0;
      end else begin
         // Depth is a power of two, so the pointers wrap Depth-1 -> 0 by
         // plain modular increment.
         if (wr_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PtrW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PtrW'(1);
         end
         level_r <= level_next_s;
         full_r  <= (level_next_s == LvlFull);
         empty_r <= (level_next_s == '0);
         if (i_wr_en & full_r) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Pacing FSM with registered send/busy/frame outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r    <= ST_IDLE;
         send_r     <= 1'b0;
         busy_r     <= 1'b0;
         frame_r    <= 8'h00;
         hold_cnt_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               send_r <= 1'b0;
               if (pop_s) begin
                  // Frame byte and pulse appear together on the next cycle.
                  frame_r <= mem_r[rd_ptr_r];
                  send_r  <= 1'b1;
                  busy_r  <= 1'b1;
                  state_r <= ST_SEND;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            ST_SEND: begin
               send_r     <= 1'b0;
               busy_r     <= 1'b1;
               hold_cnt_r <= HoldLoad;
               state_r    <= ST_WAIT;
            end
            ST_WAIT: begin
               send_r <= 1'b0;
               // HoldCycles wait cycles: counter runs HoldCycles-1 down to 0.
               if (hold_cnt_r == '0) begin
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end else begin
                  busy_r     <= 1'b1;
                  hold_cnt_r <= hold_cnt_r - CntW'(1);
               end
            end
            default: begin
               send_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_full     = full_r;
   assign o_empty    = empty_r;
   assign o_level    = level_r;
   assign o_overflow = overflow_r;
   assign o_send     = send_r;
   assign o_frame    = frame_r;
   assign o_busy     = busy_r;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_feeder
//
// Directed bench for uart_tx_feeder with ClockFrequency=10, BaudRate=1
// (TicksPerBit=10, HoldCycles=110) and Depth=4. A small serial line model
// driven by o_send/o_frame and a matching receiver decode the bytes that
// would leave the transmitter.
// -----------------------------------------------------------------------------
module tb_uart_tx_feeder;

   localparam int CF      = 10;
   localparam int BR      = 1;
   localparam int DP      = 4;
   localparam int HOLD    = 110;
   localparam int SPACING = HOLD + 2;

   logic       CLK = 1'b0;
   logic       RST;
   logic       i_wr_en;
   logic [7:0] i_wr_data;
   logic       o_full;
   logic       o_empty;
   logic [2:0] o_level;
   logic       o_overflow;
   logic       o_send;
   logic [7:0] o_frame;
   logic       o_busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int stab_err = 0;

   logic [7:0] last_frame = 8'h00;
   logic [7:0] sent_q[$];
   int         sent_t[$];
   logic [7:0] rx_q[$];
   logic       tx_line = 1'b1;
   logic [9:0] tx_bits;
   logic [7:0] rx_d;

   logic [7:0] exp_burst [3] = '{8'h01, 8'h02, 8'h03};
   logic [7:0] exp_ovf   [5] = '{8'h5A, 8'h11, 8'h22, 8'h33, 8'h44};

   uart_tx_feeder #(
      .ClockFrequency(CF),
      .BaudRate      (BR),
      .Depth         (DP)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .i_wr_en   (i_wr_en),
      .i_wr_data (i_wr_data),
      .o_full    (o_full),
      .o_empty   (o_empty),
      .o_level   (o_level),
      .o_overflow(o_overflow),
      .o_send    (o_send),
      .o_frame   (o_frame),
      .o_busy    (o_busy)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Record every pulse and watch that o_frame holds while busy.
   always @(negedge CLK) begin
      if (o_send === 1'b1) begin
         sent_q.push_back(o_frame);
         sent_t.push_back(cyc);
         last_frame <= o_frame;
      end else if (o_busy === 1'b1 && o_frame !== last_frame) begin
         stab_err <= stab_err + 1;
      end
   end

   // Serial transmitter model: 1 start, 8 data LSB first, 1 stop.
   initial begin
      forever begin
         @(negedge CLK);
         if (o_send === 1'b1) begin
            tx_bits = {1'b1, o_frame, 1'b0};
            for (int b = 0; b < 10; b++) begin
               tx_line = tx_bits[b];
               repeat (10) @(negedge CLK);
            end
            tx_line = 1'b1;
         end
      end
   end

   // Serial receiver model sampling mid-bit.
   initial begin
      forever begin
         @(posedge CLK);
         if (tx_line === 1'b0) begin
            repeat (5) @(posedge CLK);
            for (int b = 0; b < 8; b++) begin
               repeat (10) @(posedge CLK);
               rx_d[b] = tx_line;
            end
            repeat (10) @(posedge CLK);
            rx_q.push_back(rx_d);
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_empty"}, 32'(o_empty), 32'd1);
      chk({tag, "_full"},  32'(o_full),  32'd0);
      chk({tag, "_level"}, 32'(o_level), 32'd0);
      chk({tag, "_send"},  32'(o_send),  32'd0);
      chk({tag, "_busy"},  32'(o_busy),  32'd0);
      chk({tag, "_frame"}, 32'(o_frame), 32'h00);
      chk({tag, "_ovf"},   32'(o_overflow), 32'd0);
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (!(o_empty === 1'b1 && o_busy === 1'b0) && n < 1000) begin
         tick();
         n++;
      end
      chk(tag, 32'(n < 1000), 32'd1);
   endtask

   initial begin
      int n;
      int cnt0;

      RST       = 1'b1;
      i_wr_en   = 1'b0;
      i_wr_data = 8'h00;
      tick();
      tick();
      RST = 1'b0;
      chk_reset_vals("rst");

      // Single byte
      i_wr_en = 1'b1; i_wr_data = 8'hA5;
      tick();
      i_wr_en = 1'b0;
      chk("single_level1", 32'(o_level), 32'd1);
      chk("single_nempty", 32'(o_empty), 32'd0);
      chk("single_nosend", 32'(o_send),  32'd0);
      tick();
      chk("single_send",  32'(o_send),  32'd1);
      chk("single_frame", 32'(o_frame), 32'hA5);
      chk("single_busy",  32'(o_busy),  32'd1);
      chk("single_empty", 32'(o_empty), 32'd1);
      tick();
      chk("single_sendlow", 32'(o_send), 32'd0);
      chk("single_busy2",   32'(o_busy), 32'd1);
      n = 0;
      while (o_busy === 1'b1 && n < 500) begin
         tick();
         n++;
      end
      chk("single_busylen", 32'(n), 32'd110);
      chk("single_count", 32'(sent_q.size()), 32'd1);
      repeat (5) tick();

      // Burst pacing
      sent_q.delete(); sent_t.delete(); rx_q.delete();
      for (int i = 0; i < 3; i++) begin
         i_wr_en = 1'b1; i_wr_data = exp_burst[i];
         tick();
      end
      i_wr_en = 1'b0;
      wait_drain("burst_drain");
      repeat (120) tick();
      chk("burst_count", 32'(sent_q.size()), 32'd3);
      chk("burst_rxcount", 32'(rx_q.size()), 32'd3);
      if (sent_q.size() == 3 && rx_q.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("burst_frame%0d", i), 32'(sent_q[i]), 32'(exp_burst[i]));
            chk($sformatf("burst_rx%0d", i),    32'(rx_q[i]),   32'(exp_burst[i]));
         end
         chk("burst_gap01", 32'(sent_t[1] - sent_t[0]), 32'(SPACING));
         chk("burst_gap12", 32'(sent_t[2] - sent_t[1]), 32'(SPACING));
      end

      // Full / overflow and write coinciding with a pop while full
      sent_q.delete(); sent_t.delete();
      i_wr_en = 1'b1; i_wr_data = 8'h5A;
      tick();
      i_wr_en = 1'b0;
      repeat (3) tick();
      for (int i = 1; i < 5; i++) begin
         i_wr_en = 1'b1; i_wr_data = exp_ovf[i];
         tick();
      end
      chk("ovf_full",   32'(o_full),     32'd1);
      chk("ovf_level4", 32'(o_level),    32'd4);
      chk("ovf_clear",  32'(o_overflow), 32'd0);
      i_wr_data = 8'h55;
      tick();
      i_wr_en = 1'b0;
      chk("ovf_set",    32'(o_overflow), 32'd1);
      chk("ovf_keep4",  32'(o_level),    32'd4);
      n = 0;
      while (o_busy === 1'b1 && n < 500) begin
         tick();
         n++;
      end
      chk("ovf_idle_wait", 32'(n < 500), 32'd1);
      i_wr_en = 1'b1; i_wr_data = 8'h66;
      tick();
      i_wr_en = 1'b0;
      chk("simul_send",  32'(o_send),     32'd1);
      chk("simul_level", 32'(o_level),    32'd3);
      chk("simul_full",  32'(o_full),     32'd0);
      chk("simul_ovf",   32'(o_overflow), 32'd1);
      chk("simul_frame", 32'(o_frame),    32'h11);
      wait_drain("ovf_drain");
      chk("ovf_count", 32'(sent_q.size()), 32'd5);
      if (sent_q.size() == 5) begin
         for (int i = 0; i < 5; i++) begin
            chk($sformatf("ovf_frame%0d", i), 32'(sent_q[i]), 32'(exp_ovf[i]));
         end
      end
      chk("ovf_sticky", 32'(o_overflow), 32'd1);
      chk("frame_stable", 32'(stab_err), 32'd0);
      repeat (5) tick();

      // Reset in the middle of the hold with bytes queued
      for (int i = 0; i < 4; i++) begin
         i_wr_en = 1'b1; i_wr_data = 8'h71 + 8'(i);
         tick();
      end
      i_wr_en = 1'b0;
      chk("mid_queued", 32'(o_level), 32'd3);
      chk("mid_busy",   32'(o_busy),  32'd1);
      repeat (50) tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk_reset_vals("midrst");
      cnt0 = sent_q.size();
      repeat (200) tick();
      chk("midrst_nosend", 32'(sent_q.size() - cnt0), 32'd0);
      chk("midrst_empty",  32'(o_empty), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
